// File: rtl/quad_collector_if.sv
// quad_collector_if: byte-in / quad-out handshake bundle for quad_collector.
// The flush signal exists only when QUAD_FLUSH_EN is defined.
interface quad_collector_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] c;
  logic [DATA_W-1:0] d;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        fill_cnt;
`ifdef QUAD_FLUSH_EN
  logic              flush;
`endif

  // Collector side: consumes the byte stream, produces the quad.
  modport slave (
`ifdef QUAD_FLUSH_EN
    input  flush,
`endif
    input  in_data, in_valid, out_ready,
    output in_ready, a, b, c, d, out_valid, fill_cnt
  );

  // Upstream/downstream side: drives bytes, accepts quads.
  modport master (
`ifdef QUAD_FLUSH_EN
    output flush,
`endif
    output in_data, in_valid, out_ready,
    input  in_ready, a, b, c, d, out_valid, fill_cnt
  );
endinterface

// File: rtl/quad_collector.sv
// quad_collector: gathers a serial byte stream into groups of four and holds
// each group on a..d with out_valid until the downstream minimum stage takes it.
// Optional macro QUAD_FLUSH_EN adds a flush input that pads a partial group
// with PAD_VAL (all-ones, neutral for a minimum) and presents it immediately.
module quad_collector #(
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] PAD_VAL = {DATA_W{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  quad_collector_if.slave bus
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_cnt;
  logic [1:0]        w_cnt_nxt;
  logic [DATA_W-1:0] r_slot [4];

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_wr_en;
  logic [1:0]        w_wr_idx;
  logic [3:0]        w_pad_mask;
`ifdef QUAD_FLUSH_EN
  logic [2:0]        w_filled;
`endif

  assign bus.out_valid = (r_state == S_FULL);
  assign bus.in_ready  = ~bus.out_valid | bus.out_ready;
  assign bus.fill_cnt  = (r_state == S_FULL) ? 3'd4 : {1'b0, r_cnt};
  assign bus.a         = r_slot[0];
  assign bus.b         = r_slot[1];
  assign bus.c         = r_slot[2];
  assign bus.d         = r_slot[3];

  assign w_in_fire  = bus.in_valid & bus.in_ready;
  assign w_out_fire = bus.out_valid & bus.out_ready;

  // Next state, next fill count, and which slot gets written or padded.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_cnt;
    w_pad_mask  = 4'b0000;
`ifdef QUAD_FLUSH_EN
    // Bytes held after this edge, counting a byte arriving on it.
    w_filled    = {1'b0, r_cnt} + {2'b00, w_in_fire};
`endif
    unique case (r_state)
      S_FILL: begin
        if (w_in_fire) begin
          w_wr_en   = 1'b1;
          w_cnt_nxt = r_cnt + 2'd1;  // wraps to 0 as the 4th byte lands
          if (r_cnt == 2'd3) w_state_nxt = S_FULL;
        end
`ifdef QUAD_FLUSH_EN
        // Store the concurrent byte first, then pad whatever is left; a byte
        // that completes the group leaves nothing to pad.
        if (bus.flush && (w_filled != 3'd0) && (w_filled != 3'd4)) begin
          w_state_nxt = S_FULL;
          w_cnt_nxt   = 2'd0;
          for (int i = 0; i < 4; i++) begin
            w_pad_mask[i] = (3'(i) >= w_filled);
          end
        end
`endif
      end
      S_FULL: begin
        // An input transfer in FULL implies out_ready, so it coincides with
        // the output transfer and starts the next group in slot a.
        if (w_out_fire) begin
          w_state_nxt = S_FILL;
          if (w_in_fire) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = 2'd0;
            w_cnt_nxt = 2'd1;
          end
        end
      end
    endcase
  end

  // State and fill-count register; reset drops any partial or held group.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      r_state <= S_FILL;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Slot storage: write the accepted byte or load padding into open slots.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the slot array is reset on purpose because a..d must read zero
    // under reset; pure storage arrays are otherwise best left unreset.
    if (rst) begin
      for (int i = 0; i < 4; i++) r_slot[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr_en && (w_wr_idx == 2'(i))) r_slot[i] <= bus.in_data;
        else if (w_pad_mask[i])              r_slot[i] <= PAD_VAL;
      end
    end
  end

endmodule
